// File: rtl/led_axi_burst_slave.sv
// led_axi_burst_slave: AXI4 burst slave backing a small register memory.
// Independent write (AW/W/B) and read (AR/R) paths, INCR/FIXED/WRAP addressing,
// LED output mirrors the low bits of word 0.
module led_axi_burst_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int LED_WIDTH          = 8
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  // write address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [7:0]                        s00_axi_awlen,
  input  logic [2:0]                        s00_axi_awsize,
  input  logic [1:0]                        s00_axi_awburst,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wlast,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  // write response channel
  output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_bid,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  // read address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [7:0]                        s00_axi_arlen,
  input  logic [2:0]                        s00_axi_arsize,
  input  logic [1:0]                        s00_axi_arburst,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  // read data channel
  output logic [C_S_AXI_ID_WIDTH-1:0]       s00_axi_rid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rlast,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  // LED output
  output logic [LED_WIDTH-1:0]              led
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH  = 2 ** IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Word index of the next beat. WRAP with a legal length wraps inside the
  // aligned (len+1)-word window; any other WRAP length and the reserved burst
  // encoding fall back to INCR. INCR wraps naturally modulo DEPTH.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [1:0]       burst,
                                                input logic [7:0]       len);
    logic [IDX_W-1:0] inc;
    logic [IDX_W-1:0] mask;
    logic             wrap_ok;
    inc     = idx + IDX_W'(1);
    mask    = IDX_W'(len);
    wrap_ok = ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)) &&
              (32'(len) < DEPTH);
    case (burst)
      2'b00:   next_idx = idx;
      2'b10:   next_idx = wrap_ok ? ((idx & ~mask) | (inc & mask)) : inc;
      default: next_idx = inc;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                          wr_en;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_word;
  logic [LED_WIDTH-1:0]          led_q, led_d;

  // ---------------------------------------------------------------------------
  // Write path state
  // ---------------------------------------------------------------------------
  w_state_e                      w_state_q, w_state_d;
  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [IDX_W-1:0]              aw_idx_q, aw_idx_d;
  logic [7:0]                    aw_len_q, aw_len_d;
  logic [1:0]                    aw_burst_q, aw_burst_d;
  logic                          aw_size_ok_q, aw_size_ok_d;
  logic [7:0]                    w_beat_q, w_beat_d;

  // ---------------------------------------------------------------------------
  // Read path state
  // ---------------------------------------------------------------------------
  r_state_e                      r_state_q, r_state_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic                          rlast_q, rlast_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [IDX_W-1:0]              ar_idx_q, ar_idx_d;
  logic [7:0]                    ar_len_q, ar_len_d;
  logic [1:0]                    ar_burst_q, ar_burst_d;
  logic                          ar_size_ok_q, ar_size_ok_d;
  logic [7:0]                    r_beat_q, r_beat_d;
  logic [IDX_W-1:0]              rd_idx_nxt;

  // Byte-lane bits of the addresses are not needed for word-sized beats.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write FSM next-state: AW latch, per-beat byte-merge and address advance, B response
  always_comb begin
    w_state_d    = w_state_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    bid_d        = bid_q;
    aw_id_d      = aw_id_q;
    aw_idx_d     = aw_idx_q;
    aw_len_d     = aw_len_q;
    aw_burst_d   = aw_burst_q;
    aw_size_ok_d = aw_size_ok_q;
    w_beat_d     = w_beat_q;
    wr_en        = 1'b0;
    wr_word      = mem_q[aw_idx_q];
    led_d        = led_q;

    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s00_axi_awvalid && awready_q) begin
          aw_id_d      = s00_axi_awid;
          aw_idx_d     = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
          aw_len_d     = s00_axi_awlen;
          aw_burst_d   = s00_axi_awburst;
          aw_size_ok_d = (s00_axi_awsize == SIZE_WORD);
          w_beat_d     = '0;
          awready_d    = 1'b0;
          wready_d     = 1'b1;
          w_state_d    = W_DATA;
        end
      end
      W_DATA: begin
        if (s00_axi_wvalid && wready_q) begin
          // A burst with an unsupported beat size is consumed but never stored.
          wr_en = aw_size_ok_q;
          for (int b = 0; b < STRB_W; b++) begin
            if (s00_axi_wstrb[b]) begin
              wr_word[8*b +: 8] = s00_axi_wdata[8*b +: 8];
            end
          end
          aw_idx_d = next_idx(aw_idx_q, aw_burst_q, aw_len_q);
          w_beat_d = w_beat_q + 8'd1;
          if (s00_axi_wlast) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = aw_id_q;
            bresp_d   = ((w_beat_q != aw_len_q) || !aw_size_ok_q) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s00_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase

    // LED follows word 0 in the same edge that stores the new value.
    if (wr_en && (aw_idx_q == '0)) begin
      led_d = wr_word[LED_WIDTH-1:0];
    end
  end

  // Write FSM registers
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state_q    <= W_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= '0;
      bid_q        <= '0;
      aw_id_q      <= '0;
      aw_idx_q     <= '0;
      aw_len_q     <= '0;
      aw_burst_q   <= '0;
      aw_size_ok_q <= 1'b0;
      w_beat_q     <= '0;
    end else begin
      w_state_q    <= w_state_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      bid_q        <= bid_d;
      aw_id_q      <= aw_id_d;
      aw_idx_q     <= aw_idx_d;
      aw_len_q     <= aw_len_d;
      aw_burst_q   <= aw_burst_d;
      aw_size_ok_q <= aw_size_ok_d;
      w_beat_q     <= w_beat_d;
    end
  end

  // Memory array and LED register; cleared by reset so no stale data survives
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      led_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[aw_idx_q] <= wr_word;
      end
      led_q <= led_d;
    end
  end

  // Read FSM next-state: AR latch, prefetch of each beat into the rdata register
  always_comb begin
    r_state_d    = r_state_q;
    arready_d    = arready_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    rid_d        = rid_q;
    ar_idx_d     = ar_idx_q;
    ar_len_d     = ar_len_q;
    ar_burst_d   = ar_burst_q;
    ar_size_ok_d = ar_size_ok_q;
    r_beat_d     = r_beat_q;
    rd_idx_nxt   = next_idx(ar_idx_q, ar_burst_q, ar_len_q);

    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s00_axi_arvalid && arready_q) begin
          rid_d        = s00_axi_arid;
          ar_idx_d     = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
          ar_len_d     = s00_axi_arlen;
          ar_burst_d   = s00_axi_arburst;
          ar_size_ok_d = (s00_axi_arsize == SIZE_WORD);
          r_beat_d     = '0;
          // Memory is read before this edge's write lands, so a same-cycle
          // write to the same word is seen as its old value.
          rdata_d      = (s00_axi_arsize == SIZE_WORD) ?
                         mem_q[s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]] : '0;
          rresp_d      = (s00_axi_arsize == SIZE_WORD) ? RESP_OKAY : RESP_SLVERR;
          rlast_d      = (s00_axi_arlen == 8'd0);
          rvalid_d     = 1'b1;
          arready_d    = 1'b0;
          r_state_d    = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s00_axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            ar_idx_d = rd_idx_nxt;
            r_beat_d = r_beat_q + 8'd1;
            rdata_d  = ar_size_ok_q ? mem_q[rd_idx_nxt] : '0;
            rlast_d  = ((r_beat_q + 8'd1) == ar_len_q);
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read FSM registers
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state_q    <= R_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rresp_q      <= '0;
      rdata_q      <= '0;
      rid_q        <= '0;
      ar_idx_q     <= '0;
      ar_len_q     <= '0;
      ar_burst_q   <= '0;
      ar_size_ok_q <= 1'b0;
      r_beat_q     <= '0;
    end else begin
      r_state_q    <= r_state_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      rid_q        <= rid_d;
      ar_idx_q     <= ar_idx_d;
      ar_len_q     <= ar_len_d;
      ar_burst_q   <= ar_burst_d;
      ar_size_ok_q <= ar_size_ok_d;
      r_beat_q     <= r_beat_d;
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_bid     = bid_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rlast   = rlast_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rid     = rid_q;
  assign led             = led_q;

endmodule

// File: tb/tb_led_axi_burst_slave.sv
// tb_led_axi_burst_slave: table-driven bench for the AXI burst slave.
// Vectors hold one burst each with hand-computed data; multi-cycle corner
// cases (backpressure, reset mid-burst) are written out as sequences.
module tb_led_axi_burst_slave;

  localparam int LIM = 100;

  logic        clk;
  logic        rst_n;
  logic [0:0]  awid;
  logic [5:0]  awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [0:0]  arid;
  logic [5:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;

  led_axi_burst_slave #(
    .C_S_AXI_ID_WIDTH(1),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .LED_WIDTH(8)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi_awid(awid),
    .s00_axi_awaddr(awaddr),
    .s00_axi_awlen(awlen),
    .s00_axi_awsize(awsize),
    .s00_axi_awburst(awburst),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),
    .s00_axi_wstrb(wstrb),
    .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bid(bid),
    .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_arid(arid),
    .s00_axi_araddr(araddr),
    .s00_axi_arlen(arlen),
    .s00_axi_arsize(arsize),
    .s00_axi_arburst(arburst),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rid(rid),
    .s00_axi_rdata(rdata),
    .s00_axi_rresp(rresp),
    .s00_axi_rlast(rlast),
    .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            wr;
    logic            id;
    logic [5:0]      addr;
    logic [7:0]      len;
    logic [1:0]      burst;
    logic [2:0]      size;
    logic [3:0]      strb;
    logic [3:0]      nbeats;   // write beats actually sent; wlast on the final one
    logic [1:0]      resp;
    logic [7:0]      led;      // expected LED after the transaction
    logic [7:0][31:0] data;    // write data or expected read data per beat
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mkv(input logic wr, input logic id, input logic [5:0] addr,
                               input logic [7:0] len, input logic [1:0] burst,
                               input logic [2:0] size, input logic [3:0] strb,
                               input logic [3:0] nbeats, input logic [1:0] resp,
                               input logic [7:0] ledv,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [31:0] w4, input logic [31:0] w5,
                               input logic [31:0] w6, input logic [31:0] w7);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.burst = burst;
    v.size = size; v.strb = strb; v.nbeats = nbeats; v.resp = resp; v.led = ledv;
    v.data[0] = w0; v.data[1] = w1; v.data[2] = w2; v.data[3] = w3;
    v.data[4] = w4; v.data[5] = w5; v.data[6] = w6; v.data[7] = w7;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input vec_t v, input int bstall);
    int n;
    awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < LIM) begin @(posedge clk); #1; n++; end
    chk("aw_handshake_in_time", 32'(n < LIM), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < int'(v.nbeats); i++) begin
      wvalid = 1'b1; wdata = v.data[i]; wstrb = v.strb;
      wlast = (i == int'(v.nbeats) - 1);
      n = 0;
      while (!wready && n < LIM) begin @(posedge clk); #1; n++; end
      chk("w_handshake_in_time", 32'(n < LIM), 32'd1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < LIM) begin @(posedge clk); #1; n++; end
    chk("bvalid_in_time", 32'(n < LIM), 32'd1);
    for (int s = 0; s < bstall; s++) begin
      chk("bvalid_held_while_stalled", 32'(bvalid), 32'd1);
      chk("awready_low_until_b", 32'(awready), 32'd0);
      chk("bresp_stable_while_stalled", 32'(bresp), 32'(v.resp));
      @(posedge clk); #1;
    end
    bready = 1'b1;
    chk("bresp", 32'(bresp), 32'(v.resp));
    chk("bid", 32'(bid), 32'(v.id));
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_cleared", 32'(bvalid), 32'd0);
    chk("awready_after_b", 32'(awready), 32'd1);
  endtask

  task automatic axi_read(input vec_t v, input bit toggle);
    int n;
    int beat;
    int cyc;
    arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIM) begin @(posedge clk); #1; n++; end
    chk("ar_handshake_in_time", 32'(n < LIM), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_one_cycle_latency", 32'(rvalid), 32'd1);
    beat = 0;
    cyc  = 0;
    while (beat <= int'(v.len) && cyc < 4 * LIM) begin
      rready = toggle ? cyc[0] : 1'b1;
      if (rvalid) begin
        chk($sformatf("rdata_beat%0d", beat), rdata, v.data[beat]);
        chk($sformatf("rresp_beat%0d", beat), 32'(rresp), 32'(v.resp));
        chk($sformatf("rlast_beat%0d", beat), 32'(rlast), 32'(beat == int'(v.len)));
        chk($sformatf("rid_beat%0d", beat), 32'(rid), 32'(v.id));
        if (rready) beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    chk("r_burst_in_time", 32'(cyc < 4 * LIM), 32'd1);
    chk("rvalid_cleared_after_last", 32'(rvalid), 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    if (v.wr) axi_write(v, 0);
    else      axi_read(v, 1'b0);
    chk($sformatf("led_after_vec%0d", idx), 32'(led), 32'(v.led));
    $display("txn %0d %s addr=0x%02h len=%0d burst=%0d size=%0d", idx,
             v.wr ? "WR" : "RD", v.addr, v.len, v.burst, v.size);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // INCR/WRAP/FIXED/Reserved bursts; data hand-tracked through the sequence.
    vecs[0]  = mkv(1, 1, 6'h00, 7, 2'b01, 3'd2, 4'hF, 8, 2'b00, 8'h01,
                   32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    vecs[1]  = mkv(0, 1, 6'h00, 7, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h01,
                   32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    vecs[2]  = mkv(1, 0, 6'h08, 3, 2'b10, 3'd2, 4'hF, 4, 2'b00, 8'h0C,
                   32'hAAAA000A, 32'hBBBB000B, 32'hCCCC000C, 32'hDDDD000D, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 0, 6'h00, 3, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   32'hCCCC000C, 32'hDDDD000D, 32'hAAAA000A, 32'hBBBB000B, 0, 0, 0, 0);
    vecs[4]  = mkv(1, 1, 6'h20, 7, 2'b01, 3'd2, 4'hF, 4, 2'b10, 8'h0C,
                   32'h100, 32'h101, 32'h102, 32'h103, 0, 0, 0, 0);
    vecs[5]  = mkv(0, 1, 6'h20, 3, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   32'h100, 32'h101, 32'h102, 32'h103, 0, 0, 0, 0);
    vecs[6]  = mkv(1, 0, 6'h10, 2, 2'b00, 3'd2, 4'hF, 3, 2'b00, 8'h0C,
                   32'h55, 32'h66, 32'h77, 0, 0, 0, 0, 0);
    vecs[7]  = mkv(0, 0, 6'h10, 2, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   32'h77, 32'd6, 32'd7, 0, 0, 0, 0, 0);
    vecs[8]  = mkv(1, 1, 6'h04, 0, 2'b01, 3'd2, 4'hF, 1, 2'b00, 8'h0C,
                   32'h11223344, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mkv(1, 1, 6'h04, 0, 2'b01, 3'd2, 4'h1, 1, 2'b00, 8'h0C,
                   32'hAABBCCDD, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mkv(0, 1, 6'h04, 0, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   32'h112233DD, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mkv(1, 0, 6'h30, 1, 2'b01, 3'd3, 4'hF, 2, 2'b10, 8'h0C,
                   32'hDEAD0001, 32'hDEAD0002, 0, 0, 0, 0, 0, 0);
    vecs[12] = mkv(0, 0, 6'h30, 1, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mkv(0, 1, 6'h00, 1, 2'b01, 3'd3, 4'hF, 0, 2'b10, 8'h0C,
                   0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mkv(0, 0, 6'h0C, 3, 2'b10, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   32'hBBBB000B, 32'hCCCC000C, 32'h112233DD, 32'hAAAA000A, 0, 0, 0, 0);
    vecs[15] = mkv(0, 1, 6'h3C, 1, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   32'h0, 32'hCCCC000C, 0, 0, 0, 0, 0, 0);
    vecs[16] = mkv(0, 0, 6'h08, 2, 2'b10, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   32'hAAAA000A, 32'hBBBB000B, 32'h77, 0, 0, 0, 0, 0);
    vecs[17] = mkv(0, 1, 6'h18, 1, 2'b11, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                   32'd7, 32'd8, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;

    // Reset state and first-edge ready rise
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("awready_first_edge", 32'(awready), 32'd1);
    chk("arready_first_edge", 32'(arready), 32'd1);

    for (int i = 0; i < 18; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: B held off 10 cycles, then read with rready toggling
    axi_write(mkv(1, 1, 6'h28, 1, 2'b01, 3'd2, 4'hF, 2, 2'b00, 8'h0C,
                  32'h200, 32'h201, 0, 0, 0, 0, 0, 0), 10);
    $display("txn stall-b WR addr=0x28 len=1");
    axi_read(mkv(0, 0, 6'h00, 7, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                 32'hCCCC000C, 32'h112233DD, 32'hAAAA000A, 32'hBBBB000B,
                 32'h77, 32'd6, 32'd7, 32'd8), 1'b1);
    $display("txn stall-r RD addr=0x00 len=7 rready toggling");
    axi_read(mkv(0, 1, 6'h28, 1, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h0C,
                 32'h200, 32'h201, 0, 0, 0, 0, 0, 0), 1'b0);
    $display("txn stall-b readback RD addr=0x28 len=1");

    // Reset after beat 3 of an 8-beat write
    begin
      int n;
      awid = 1'b0; awaddr = 6'h00; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01;
      awvalid = 1'b1;
      n = 0;
      while (!awready && n < LIM) begin @(posedge clk); #1; n++; end
      chk("rstburst_aw_in_time", 32'(n < LIM), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        wvalid = 1'b1; wdata = 32'h50 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
        n = 0;
        while (!wready && n < LIM) begin @(posedge clk); #1; n++; end
        chk("rstburst_w_in_time", 32'(n < LIM), 32'd1);
        @(posedge clk); #1;
      end
      chk("led_before_reset", 32'(led), 32'h50);
      rst_n = 1'b0;
      #1;
      wvalid = 1'b0;
      chk("midrst_awready", 32'(awready), 32'd0);
      chk("midrst_wready", 32'(wready), 32'd0);
      chk("midrst_bvalid", 32'(bvalid), 32'd0);
      chk("midrst_arready", 32'(arready), 32'd0);
      chk("midrst_rvalid", 32'(rvalid), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      chk("midrst_led", 32'(led), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        chk("no_bvalid_after_reset", 32'(bvalid), 32'd0);
      end
      $display("txn reset-mid-burst WR addr=0x00 len=7 aborted after 3 beats");
    end
    axi_read(mkv(0, 0, 6'h00, 7, 2'b01, 3'd2, 4'hF, 0, 2'b00, 8'h00,
                 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("led_after_reset", 32'(led), 32'd0);
    $display("txn post-reset RD addr=0x00 len=7 expect zeros");
    run_vec(100, vecs[0]);
    run_vec(101, vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
